// File: rtl/ysyx_25020037_alu_issue.sv
// Decode/issue stage between IFU and EXU: decodes one RV32I instruction per accept
// and presents a registered one-hot ALU opcode, four operands and writeback/jump info.
module ysyx_25020037_alu_issue #(
    parameter int XLEN = 32,
    parameter int OP_W = 17
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_inst,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] alu_op,
    output logic            double_cal,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [XLEN-1:0] alu_src3,
    output logic [XLEN-1:0] alu_src4,
    output logic [4:0]      rd,
    output logic            rd_wen,
    output logic            jmp,
    output logic [XLEN-1:0] jmp_target,
    output logic            illegal
);
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_SLL  = 7;
    localparam int OP_SRL  = 8;
    localparam int OP_SRA  = 9;
    localparam int OP_LUI  = 10;
    localparam int OP_BNE  = 11;
    localparam int OP_BEQ  = 12;
    localparam int OP_BGE  = 13;
    localparam int OP_BGEU = 14;
    localparam int OP_BLT  = 15;
    localparam int OP_BLTU = 16;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Handshake: in_valid/in_ready on the IFU side and out_valid/out_ready on the EXU side;
    // a transfer happens on an edge where both are high, and a held output never changes.
    logic            out_valid_q, out_valid_d;
    logic [OP_W-1:0] alu_op_q;
    logic            double_cal_q, rd_wen_q, jmp_q, illegal_q;
    logic [XLEN-1:0] src1_q, src2_q, src3_q, src4_q, jmp_target_q;
    logic [4:0]      rd_q;
    logic            accept;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [OP_W-1:0] dec_op;
    logic            dec_legal, dec_dc, dec_wb, dec_jmp;
    logic [XLEN-1:0] dec_s1, dec_s2, dec_s3, dec_s4, dec_tgt;

    assign opcode = in_inst[6:0];
    assign rd_f   = in_inst[11:7];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    assign imm_i = {{21{in_inst[31]}}, in_inst[30:20]};
    assign imm_s = {{21{in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
    assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    assign in_ready = (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_op    = '0;
        dec_legal = 1'b1;
        dec_dc    = 1'b0;
        dec_wb    = 1'b0;
        dec_jmp   = 1'b0;
        dec_s1    = '0;
        dec_s2    = '0;
        dec_s3    = '0;
        dec_s4    = '0;
        dec_tgt   = '0;
        case (opcode)
            OPC_OP: begin
                dec_wb = 1'b1;
                dec_s1 = rs1_data;
                dec_s2 = rs2_data;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec_op[OP_ADD]  = 1'b1;
                    {7'h20, 3'b000}: dec_op[OP_SUB]  = 1'b1;
                    {7'h00, 3'b001}: dec_op[OP_SLL]  = 1'b1;
                    {7'h00, 3'b010}: dec_op[OP_SLT]  = 1'b1;
                    {7'h00, 3'b011}: dec_op[OP_SLTU] = 1'b1;
                    {7'h00, 3'b100}: dec_op[OP_XOR]  = 1'b1;
                    {7'h00, 3'b101}: dec_op[OP_SRL]  = 1'b1;
                    {7'h20, 3'b101}: dec_op[OP_SRA]  = 1'b1;
                    {7'h00, 3'b110}: dec_op[OP_OR]   = 1'b1;
                    {7'h00, 3'b111}: dec_op[OP_AND]  = 1'b1;
                    default:         dec_legal       = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec_wb = 1'b1;
                dec_s1 = rs1_data;
                dec_s2 = imm_i;
                case (funct3)
                    3'b000: dec_op[OP_ADD]  = 1'b1;
                    3'b010: dec_op[OP_SLT]  = 1'b1;
                    3'b011: dec_op[OP_SLTU] = 1'b1;
                    3'b100: dec_op[OP_XOR]  = 1'b1;
                    3'b110: dec_op[OP_OR]   = 1'b1;
                    3'b111: dec_op[OP_AND]  = 1'b1;
                    3'b001: begin
                        dec_s2 = {27'b0, in_inst[24:20]};
                        if (funct7 == 7'h00) dec_op[OP_SLL] = 1'b1;
                        else dec_legal = 1'b0;
                    end
                    default: begin
                        // funct3 101: srli/srai share the encoding, told apart by funct7
                        dec_s2 = {27'b0, in_inst[24:20]};
                        if (funct7 == 7'h00) dec_op[OP_SRL] = 1'b1;
                        else if (funct7 == 7'h20) dec_op[OP_SRA] = 1'b1;
                        else dec_legal = 1'b0;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_wb         = 1'b1;
                dec_op[OP_LUI] = 1'b1;
                dec_s2         = imm_u;
            end
            OPC_AUIPC: begin
                dec_wb         = 1'b1;
                dec_op[OP_ADD] = 1'b1;
                dec_s1         = in_pc;
                dec_s2         = imm_u;
            end
            OPC_LOAD: begin
                dec_wb         = 1'b1;
                dec_op[OP_ADD] = 1'b1;
                dec_s1         = rs1_data;
                dec_s2         = imm_i;
                dec_legal      = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OPC_STORE: begin
                dec_op[OP_ADD] = 1'b1;
                dec_s1         = rs1_data;
                dec_s2         = imm_s;
                dec_legal      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OPC_JAL: begin
                dec_wb         = 1'b1;
                dec_jmp        = 1'b1;
                dec_op[OP_ADD] = 1'b1;
                dec_s1         = in_pc;
                dec_s2         = 32'd4;
                dec_tgt        = in_pc + imm_j;
            end
            OPC_JALR: begin
                dec_wb         = 1'b1;
                dec_jmp        = 1'b1;
                dec_op[OP_ADD] = 1'b1;
                dec_s1         = in_pc;
                dec_s2         = 32'd4;
                dec_tgt        = (rs1_data + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
                dec_legal      = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                // EXU computes pc+imm on src1/src2 and the compare on src3/src4 in parallel
                dec_dc = 1'b1;
                dec_s1 = in_pc;
                dec_s2 = imm_b;
                dec_s3 = rs1_data;
                dec_s4 = rs2_data;
                case (funct3)
                    3'b000:  dec_op[OP_BEQ]  = 1'b1;
                    3'b001:  dec_op[OP_BNE]  = 1'b1;
                    3'b100:  dec_op[OP_BLT]  = 1'b1;
                    3'b101:  dec_op[OP_BGE]  = 1'b1;
                    3'b110:  dec_op[OP_BLTU] = 1'b1;
                    3'b111:  dec_op[OP_BGEU] = 1'b1;
                    default: dec_legal       = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_op  = '0;
            dec_dc  = 1'b0;
            dec_wb  = 1'b0;
            dec_jmp = 1'b0;
            dec_s1  = '0;
            dec_s2  = '0;
            dec_s3  = '0;
            dec_s4  = '0;
            dec_tgt = '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (accept)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            alu_op_q     <= '0;
            double_cal_q <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            src3_q       <= '0;
            src4_q       <= '0;
            rd_q         <= '0;
            rd_wen_q     <= 1'b0;
            jmp_q        <= 1'b0;
            jmp_target_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                alu_op_q     <= dec_op;
                double_cal_q <= dec_dc;
                src1_q       <= dec_s1;
                src2_q       <= dec_s2;
                src3_q       <= dec_s3;
                src4_q       <= dec_s4;
                rd_q         <= rd_f;
                rd_wen_q     <= dec_wb && (rd_f != 5'd0);
                jmp_q        <= dec_jmp;
                jmp_target_q <= dec_tgt;
                illegal_q    <= !dec_legal;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_op     = alu_op_q;
    assign double_cal = double_cal_q;
    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign alu_src3   = src3_q;
    assign alu_src4   = src4_q;
    assign rd         = rd_q;
    assign rd_wen     = rd_wen_q;
    assign jmp        = jmp_q;
    assign jmp_target = jmp_target_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_ysyx_25020037_alu_issue.sv
// Directed bench for the ALU issue stage: a table of decoded instructions plus
// hand-written backpressure, flush and mid-operation reset sequences.
module tb_ysyx_25020037_alu_issue;
    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] alu_op;
    logic        double_cal;
    logic [31:0] alu_src1, alu_src2, alu_src3, alu_src4;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        illegal;

    int tests_run = 0;
    int tests_failed = 0;

    ysyx_25020037_alu_issue dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .flush      (flush),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_op     (alu_op),
        .double_cal (double_cal),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_src3   (alu_src3),
        .alu_src4   (alu_src4),
        .rd         (rd),
        .rd_wen     (rd_wen),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .illegal    (illegal)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [16:0] op;
        logic        dc;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] s3;
        logic [31:0] s4;
        logic [4:0]  rd;
        logic        wen;
        logic        jmp;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    task automatic check_vec(input vec_t v);
        chk({v.name, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({v.name, ".alu_op"}, {15'b0, alu_op}, {15'b0, v.op});
        chk({v.name, ".double_cal"}, {31'b0, double_cal}, {31'b0, v.dc});
        chk({v.name, ".illegal"}, {31'b0, illegal}, {31'b0, v.ill});
        chk({v.name, ".rd_wen"}, {31'b0, rd_wen}, {31'b0, v.wen});
        chk({v.name, ".jmp"}, {31'b0, jmp}, {31'b0, v.jmp});
        if (!v.ill) begin
            chk({v.name, ".src1"}, alu_src1, v.s1);
            chk({v.name, ".src2"}, alu_src2, v.s2);
            chk({v.name, ".src3"}, alu_src3, v.s3);
            chk({v.name, ".src4"}, alu_src4, v.s4);
        end
        if (v.wen) chk({v.name, ".rd"}, {27'b0, rd}, {27'b0, v.rd});
        if (v.jmp) chk({v.name, ".jmp_target"}, jmp_target, v.tgt);
    endtask

    initial begin
        //          name     inst          pc            rs1           rs2           op        dc    s1            s2            s3     s4     rd  wen   jmp   tgt           ill
        vecs[0]  = '{"add",   32'h002081B3, 32'h00000100, 32'd5,        32'd7,        17'h00001, 1'b0, 32'd5,        32'd7,        32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{"beq",   32'h00208463, 32'h80000000, 32'h11,       32'h22,       17'h01000, 1'b1, 32'h80000000, 32'd8,        32'h11, 32'h22, 5'd8, 1'b0, 1'b0, 32'h0,     1'b0};
        vecs[2]  = '{"srai",  32'h40335293, 32'h00000104, 32'hF0,       32'h9,        17'h00200, 1'b0, 32'hF0,       32'd3,        32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{"lui",   32'h123450B7, 32'h00000108, 32'hAA,       32'hBB,       17'h00400, 1'b0, 32'd0,        32'h12345000, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{"sub",   32'h40208233, 32'h0000010C, 32'h10,       32'h3,        17'h00002, 1'b0, 32'h10,       32'h3,        32'd0, 32'd0, 5'd4, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[5]  = '{"addi",  32'hFFF00093, 32'h00000110, 32'h0,        32'h0,        17'h00001, 1'b0, 32'h0,        32'hFFFFFFFF, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{"sltu",  32'h0020B2B3, 32'h00000114, 32'h1,        32'h2,        17'h00008, 1'b0, 32'h1,        32'h2,        32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[7]  = '{"jal",   32'h010000EF, 32'h00001000, 32'h0,        32'h0,        17'h00001, 1'b0, 32'h00001000, 32'd4,        32'd0, 32'd0, 5'd1, 1'b1, 1'b1, 32'h00001010, 1'b0};
        vecs[8]  = '{"jalr",  32'h00408067, 32'h00001004, 32'h2003,     32'h0,        17'h00001, 1'b0, 32'h00001004, 32'd4,        32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'h00002006, 1'b0};
        vecs[9]  = '{"sw",    32'h0020A423, 32'h00000200, 32'h300,      32'h55,       17'h00001, 1'b0, 32'h300,      32'd8,        32'd0, 32'd0, 5'd8, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[10] = '{"lw",    32'hFFC0A283, 32'h00000204, 32'h300,      32'h0,        17'h00001, 1'b0, 32'h300,      32'hFFFFFFFC, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[11] = '{"auipc", 32'h00001397, 32'h00000400, 32'h0,        32'h0,        17'h00001, 1'b0, 32'h400,      32'h1000,     32'd0, 32'd0, 5'd7, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[12] = '{"bltu",  32'hFE20EEE3, 32'h00000500, 32'h3,        32'h9,        17'h10000, 1'b1, 32'h500,      32'hFFFFFFFC, 32'h3, 32'h9, 5'd29, 1'b0, 1'b0, 32'h0,       1'b0};
        vecs[13] = '{"allone",32'hFFFFFFFF, 32'h00000600, 32'h1,        32'h2,        17'h00000, 1'b0, 32'h0,        32'h0,        32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[14] = '{"badf7", 32'h022081B3, 32'h00000604, 32'h1,        32'h2,        17'h00000, 1'b0, 32'h0,        32'h0,        32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'h0,        1'b1};

        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.alu_op", {15'b0, alu_op}, 32'd0);
        chk("rst.illegal", {31'b0, illegal}, 32'd0);
        chk("rst.jmp", {31'b0, jmp}, 32'd0);
        chk("rst.src1", alu_src1, 32'd0);
        reset_n = 1'b1;
        chk("idle.in_ready", {31'b0, in_ready}, 32'd1);

        // table: one instruction per cycle with the EXU always ready
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            #1;
            chk({vecs[i].name, ".in_ready"}, {31'b0, in_ready}, 32'd1);
            step();
            check_vec(vecs[i]);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("drain.out_valid", {31'b0, out_valid}, 32'd0);

        // backpressure: issue add, then stall three cycles with a different op waiting
        drive(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7);
        #1;
        chk("bp.rs1_addr", {27'b0, rs1_addr}, 32'd1);
        chk("bp.rs2_addr", {27'b0, rs2_addr}, 32'd2);
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h123450B7, 32'h104, 32'hAA, 32'hBB);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
            step();
            chk("bp.out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp.alu_op", {15'b0, alu_op}, 32'h00001);
            chk("bp.src1", alu_src1, 32'd5);
            chk("bp.src2", alu_src2, 32'd7);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp.load.out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp.load.alu_op", {15'b0, alu_op}, 32'h00400);
        chk("bp.load.src2", alu_src2, 32'h12345000);

        // flush with a held op and a waiting input: nothing loaded, output killed
        out_ready = 1'b0;
        drive(1'b1, 32'h40208233, 32'h108, 32'h10, 32'h3);
        flush = 1'b1;
        #1;
        chk("flush.in_ready", {31'b0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        chk("flush.out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush.alu_op_kept", {15'b0, alu_op}, 32'h00400);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("flush.idle.out_valid", {31'b0, out_valid}, 32'd0);

        // reset while an op is held under backpressure
        drive(1'b1, 32'h010000EF, 32'h1000, 32'h0, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("midrst.pre.jmp", {31'b0, jmp}, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst.alu_op", {15'b0, alu_op}, 32'd0);
        chk("midrst.jmp", {31'b0, jmp}, 32'd0);
        chk("midrst.jmp_target", jmp_target, 32'd0);
        chk("midrst.src1", alu_src1, 32'd0);
        chk("midrst.rd", {27'b0, rd}, 32'd0);
        chk("midrst.rd_wen", {31'b0, rd_wen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
